// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the hazard/forwarding scoreboard.
// Covers the in-flight entry layout, the forward-select width and the default depths.
package hazard_scoreboard_pkg;

    typedef logic       Signal;
    typedef logic [4:0] RegAddr;

    localparam int DEFAULT_DEPTH      = 3;
    localparam int DEFAULT_LOAD_READY = 2;

    typedef struct packed {
        Signal  valid;
        RegAddr dst;
        Signal  is_load;
    } SB_entry;

    typedef logic [$clog2(DEFAULT_DEPTH+1)-1:0] FwdSel;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between the decode stage and the hazard scoreboard.
// The master modport is decode; the slave modport is the scoreboard.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int RegAddrWidth = $bits(RegAddr),
    parameter int NUM_SRC      = 2,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int CNT_W        = 16
);
    localparam int FW = $clog2(DEPTH+1);

    logic                            id_valid;
    logic [NUM_SRC*RegAddrWidth-1:0] id_src_addr;
    logic [NUM_SRC-1:0]              id_src_used;
    logic [RegAddrWidth-1:0]         id_dst_addr;
    logic                            id_reg_write;
    logic                            id_is_load;
    logic                            ex_redirect;

    logic                            issue;
    logic                            stall;
    logic                            flush;
    logic [NUM_SRC*FW-1:0]           fwd_sel;
    logic [CNT_W-1:0]                stall_count;

    modport master (
        output id_valid, id_src_addr, id_src_used, id_dst_addr,
               id_reg_write, id_is_load, ex_redirect,
        input  issue, stall, flush, fwd_sel, stall_count
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_used, id_dst_addr,
               id_reg_write, id_is_load, ex_redirect,
        output issue, stall, flush, fwd_sel, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard_sb_src_match.sv
// Youngest-match priority encoder for one source operand against all in-flight entries.
// Returns whether anything matched, the forward select (k+1), and the matching entry's load flag/index.
module sb_src_match
    import hazard_scoreboard_pkg::*;
#(
    parameter  int RegAddrWidth = $bits(RegAddr),
    parameter  int DEPTH        = DEFAULT_DEPTH,
    localparam int FW           = $clog2(DEPTH+1),
    localparam int KW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0]              ent_valid,
    input  logic [DEPTH*RegAddrWidth-1:0] ent_dst,
    input  logic [DEPTH-1:0]              ent_load,
    input  logic [RegAddrWidth-1:0]       src,
    input  logic                          src_used,
    output logic                          hit,
    output logic [FW-1:0]                 sel,
    output logic                          hit_is_load,
    output logic [KW-1:0]                 hit_k
);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit         = 1'b0;
        sel         = '0;
        hit_is_load = 1'b0;
        hit_k       = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (ent_valid[k] && src_used && (src != '0) &&
                (ent_dst[k*RegAddrWidth +: RegAddrWidth] == src)) begin
                hit         = 1'b1;
                sel         = FW'(k + 1);
                hit_is_load = ent_load[k];
                hit_k       = KW'(k);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit: tracks in-flight destinations, drives forward selects,
// load-use stall, redirect flush and a saturating stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int RegAddrWidth = $bits(RegAddr),
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int NUM_SRC      = 2,
    parameter int LOAD_READY   = DEFAULT_LOAD_READY,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_scoreboard_if.slave bus
);
    localparam int RW = RegAddrWidth;
    localparam int FW = $clog2(DEPTH+1);
    localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]    ent_vld_p;
    logic [DEPTH-1:0]    ent_load_p;
    logic [DEPTH*RW-1:0] ent_dst_p;
    logic [CNT_W-1:0]    stall_cnt;

    logic [NUM_SRC-1:0]  hit;
    logic [NUM_SRC-1:0]  hit_load;
    logic [KW-1:0]       hit_k [NUM_SRC];
    logic [NUM_SRC-1:0]  src_hazard;
    logic                stall_w;
    logic                issue_w;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        sb_src_match #(
            .RegAddrWidth(RW),
            .DEPTH       (DEPTH)
        ) u_match (
            .ent_valid  (ent_vld_p),
            .ent_dst    (ent_dst_p),
            .ent_load   (ent_load_p),
            .src        (bus.id_src_addr[i*RW +: RW]),
            .src_used   (bus.id_src_used[i]),
            .hit        (hit[i]),
            .sel        (bus.fwd_sel[i*FW +: FW]),
            .hit_is_load(hit_load[i]),
            .hit_k      (hit_k[i])
        );
    end

    // Only the youngest match counts: an older ready producer cannot hide a young load.
    always_comb begin
        src_hazard = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_hazard[i] = hit[i] & hit_load[i] & (int'(hit_k[i]) < LOAD_READY);
        end
    end

    assign stall_w         = bus.id_valid & ~bus.ex_redirect & (|src_hazard);
    assign issue_w         = bus.id_valid & ~stall_w & ~bus.ex_redirect;
    assign bus.stall       = stall_w;
    assign bus.issue       = issue_w;
    assign bus.flush       = bus.ex_redirect;
    assign bus.stall_count = stall_cnt;

    // ID -> entry 0 -> ... -> entry DEPTH-1: entries always advance, stalls only bubble entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld_p <= '0;
            stall_cnt <= '0;
        end else begin
            ent_vld_p[0] <= issue_w & bus.id_reg_write;
            for (int k = 1; k < DEPTH; k++) begin
                ent_vld_p[k] <= ent_vld_p[k-1];
            end
            if (stall_w) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        ent_dst_p[0 +: RW] <= bus.id_dst_addr;
        ent_load_p[0]      <= bus.id_is_load;
        for (int k = 1; k < DEPTH; k++) begin
            ent_dst_p[k*RW +: RW] <= ent_dst_p[(k-1)*RW +: RW];
            ent_load_p[k]         <= ent_load_p[k-1];
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against a queue-based model.
// A second instance with a 2-bit counter shares the inputs to exercise saturation.
module tb_hazard_scoreboard;
    localparam int RW    = 5;
    localparam int DEPTH = 3;
    localparam int NSRC  = 2;
    localparam int LR    = 2;
    localparam int CW    = 16;
    localparam int FW    = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.RegAddrWidth(RW), .NUM_SRC(NSRC), .DEPTH(DEPTH), .CNT_W(CW)) sb ();
    hazard_scoreboard_if #(.RegAddrWidth(RW), .NUM_SRC(NSRC), .DEPTH(DEPTH), .CNT_W(2))  sb2 ();

    hazard_scoreboard #(.RegAddrWidth(RW), .DEPTH(DEPTH), .NUM_SRC(NSRC), .LOAD_READY(LR), .CNT_W(CW))
        dut (.clk(clk), .rst(rst), .bus(sb.slave));
    hazard_scoreboard #(.RegAddrWidth(RW), .DEPTH(DEPTH), .NUM_SRC(NSRC), .LOAD_READY(LR), .CNT_W(2))
        dut2 (.clk(clk), .rst(rst), .bus(sb2.slave));

    assign sb2.id_valid     = sb.id_valid;
    assign sb2.id_src_addr  = sb.id_src_addr;
    assign sb2.id_src_used  = sb.id_src_used;
    assign sb2.id_dst_addr  = sb.id_dst_addr;
    assign sb2.id_reg_write = sb.id_reg_write;
    assign sb2.id_is_load   = sb.id_is_load;
    assign sb2.ex_redirect  = sb.ex_redirect;

    // Reference model: history of what entered the pipe each cycle, youngest first.
    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       ld;
    } rec_t;

    rec_t        hist[$];
    int unsigned stalls = 0;

    function automatic int young(input int i);
        bit [4:0] s;
        s = sb.id_src_addr[i*RW +: RW];
        if (!sb.id_src_used[i] || s == 5'd0) return -1;
        foreach (hist[k]) begin
            if (hist[k].v && hist[k].d == s) return k;
        end
        return -1;
    endfunction

    function automatic bit m_stall();
        if (!sb.id_valid || sb.ex_redirect) return 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            int k;
            k = young(i);
            if (k >= 0 && k < LR && hist[k].ld) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_issue();
        return sb.id_valid && !sb.ex_redirect && !m_stall();
    endfunction

    function automatic int m_fwd(input int i);
        int k;
        k = young(i);
        return (k < 0) ? 0 : k + 1;
    endfunction

    function automatic int unsigned m_cnt(input int unsigned maxv);
        return (stalls > maxv) ? maxv : stalls;
    endfunction

    function automatic logic [FW-1:0] dut_fwd(input int i);
        return sb.fwd_sel[i*FW +: FW];
    endfunction

    task automatic drive(input bit v, input bit [4:0] s0, input bit [4:0] s1, input bit [1:0] used,
                         input bit [4:0] d, input bit rw, input bit ld, input bit redir);
        sb.id_valid     = v;
        sb.id_src_addr  = {s1, s0};
        sb.id_src_used  = used;
        sb.id_dst_addr  = d;
        sb.id_reg_write = rw;
        sb.id_is_load   = ld;
        sb.ex_redirect  = redir;
        #1;
    endtask

    task automatic tick();
        rec_t r;
        r.v  = m_issue() && sb.id_reg_write;
        r.d  = sb.id_dst_addr;
        r.ld = sb.id_is_load;
        if (m_stall()) stalls++;
        hist.push_front(r);
        if (hist.size() > DEPTH) void'(hist.pop_back());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0, 0);
        n_tests++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", sb.stall); end
        n_tests++; if (dut_fwd(0) !== 2'd0) begin n_fail++; $display("FAIL reset_fwd0: got %0d want 0", dut_fwd(0)); end
        n_tests++; if (dut_fwd(1) !== 2'd0) begin n_fail++; $display("FAIL reset_fwd1: got %0d want 0", dut_fwd(1)); end
        n_tests++; if (sb.issue !== 1'b1) begin n_fail++; $display("FAIL reset_issue: got %b want 1", sb.issue); end
        n_tests++; if (sb.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", sb.flush); end
        n_tests++; if (sb.stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", sb.stall_count); end
        drive(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0, 1);
        n_tests++; if (sb.issue !== 1'b0) begin n_fail++; $display("FAIL reset_issue_redir: got %b want 0", sb.issue); end
        n_tests++; if (sb.flush !== 1'b1) begin n_fail++; $display("FAIL reset_flush_redir: got %b want 1", sb.flush); end
        drive(0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0);
        rst = 1'b0;
        hist.delete();
        stalls = 0;
        tick();
    endtask

    task automatic test_forward_chain();
        drive(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0, 0);
        tick();
        drive(1, 5'd3, 5'd0, 2'b01, 5'd6, 1, 0, 0);
        n_tests++; if (dut_fwd(0) !== 2'd1) begin n_fail++; $display("FAIL fwd_x: got %0d want 1", dut_fwd(0)); end
        n_tests++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL fwd_x_stall: got %b want 0", sb.stall); end
        tick();
        drive(1, 5'd3, 5'd0, 2'b01, 5'd7, 1, 0, 0);
        n_tests++; if (dut_fwd(0) !== 2'd2) begin n_fail++; $display("FAIL fwd_m: got %0d want 2", dut_fwd(0)); end
        tick();
        drive(1, 5'd3, 5'd0, 2'b01, 5'd8, 1, 0, 0);
        n_tests++; if (dut_fwd(0) !== 2'd3) begin n_fail++; $display("FAIL fwd_wb: got %0d want 3", dut_fwd(0)); end
        tick();
        drive(1, 5'd3, 5'd0, 2'b01, 5'd9, 1, 0, 0);
        n_tests++; if (dut_fwd(0) !== 2'd0) begin n_fail++; $display("FAIL fwd_retired: got %0d want 0", dut_fwd(0)); end
        tick();
    endtask

    task automatic test_load_use();
        int unsigned c0;
        drive(1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 1, 0);
        tick();
        drive(1, 5'd1, 5'd5, 2'b10, 5'd7, 1, 0, 0);
        c0 = sb.stall_count;
        n_tests++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall_k0: got %b want 1", sb.stall); end
        n_tests++; if (sb.issue !== 1'b0) begin n_fail++; $display("FAIL lu_issue_k0: got %b want 0", sb.issue); end
        tick();
        // load now at entry 1, still short of LOAD_READY = 2
        n_tests++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall_k1: got %b want 1", sb.stall); end
        n_tests++; if (dut_fwd(1) !== 2'd2) begin n_fail++; $display("FAIL lu_fwd_k1: got %0d want 2", dut_fwd(1)); end
        n_tests++; if (sb.stall_count !== 16'(c0 + 1)) begin n_fail++; $display("FAIL lu_count1: got %0d want %0d", sb.stall_count, c0 + 1); end
        tick();
        n_tests++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_k2: got %b want 0", sb.stall); end
        n_tests++; if (sb.issue !== 1'b1) begin n_fail++; $display("FAIL lu_issue_k2: got %b want 1", sb.issue); end
        n_tests++; if (dut_fwd(1) !== 2'd3) begin n_fail++; $display("FAIL lu_fwd_k2: got %0d want 3", dut_fwd(1)); end
        n_tests++; if (sb.stall_count !== 16'(c0 + 2)) begin n_fail++; $display("FAIL lu_count2: got %0d want %0d", sb.stall_count, c0 + 2); end
        tick();
    endtask

    task automatic test_r0_unused();
        drive(1, 5'd1, 5'd2, 2'b11, 5'd0, 1, 0, 0);
        tick();
        drive(1, 5'd0, 5'd0, 2'b00, 5'd9, 1, 1, 0);
        tick();
        drive(1, 5'd0, 5'd9, 2'b01, 5'd10, 1, 0, 0);
        n_tests++; if (dut_fwd(0) !== 2'd0) begin n_fail++; $display("FAIL r0_fwd: got %0d want 0", dut_fwd(0)); end
        n_tests++; if (dut_fwd(1) !== 2'd0) begin n_fail++; $display("FAIL unused_fwd: got %0d want 0", dut_fwd(1)); end
        n_tests++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL unused_stall: got %b want 0", sb.stall); end
        n_tests++; if (sb.issue !== 1'b1) begin n_fail++; $display("FAIL unused_issue: got %b want 1", sb.issue); end
        tick();
    endtask

    task automatic test_youngest();
        drive(1, 5'd0, 5'd0, 2'b00, 5'd4, 1, 0, 0);
        tick();
        drive(0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0);
        tick();
        drive(1, 5'd0, 5'd0, 2'b00, 5'd4, 1, 0, 0);
        tick();
        drive(1, 5'd4, 5'd4, 2'b11, 5'd0, 0, 0, 0);
        n_tests++; if (dut_fwd(0) !== 2'd1) begin n_fail++; $display("FAIL young_fwd0: got %0d want 1", dut_fwd(0)); end
        n_tests++; if (dut_fwd(1) !== 2'd1) begin n_fail++; $display("FAIL young_fwd1: got %0d want 1", dut_fwd(1)); end
        tick();
        drive(1, 5'd0, 5'd0, 2'b00, 5'd4, 1, 1, 0);
        tick();
        drive(1, 5'd4, 5'd0, 2'b01, 5'd0, 0, 0, 0);
        n_tests++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL young_load_stall: got %b want 1", sb.stall); end
        n_tests++; if (dut_fwd(0) !== 2'd1) begin n_fail++; $display("FAIL young_load_fwd: got %0d want 1", dut_fwd(0)); end
        tick();
        drive(0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_redirect();
        int unsigned c0;
        drive(1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 1, 0);
        tick();
        drive(1, 5'd5, 5'd0, 2'b01, 5'd6, 1, 1, 1);
        c0 = sb.stall_count;
        n_tests++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL redir_stall: got %b want 0", sb.stall); end
        n_tests++; if (sb.flush !== 1'b1) begin n_fail++; $display("FAIL redir_flush: got %b want 1", sb.flush); end
        n_tests++; if (sb.issue !== 1'b0) begin n_fail++; $display("FAIL redir_issue: got %b want 0", sb.issue); end
        tick();
        drive(1, 5'd6, 5'd5, 2'b11, 5'd0, 0, 0, 0);
        n_tests++; if (dut_fwd(0) !== 2'd0) begin n_fail++; $display("FAIL redir_bubble_fwd: got %0d want 0", dut_fwd(0)); end
        n_tests++; if (dut_fwd(1) !== 2'd2) begin n_fail++; $display("FAIL redir_older_fwd: got %0d want 2", dut_fwd(1)); end
        n_tests++; if (sb.stall_count !== 16'(c0)) begin n_fail++; $display("FAIL redir_count: got %0d want %0d", sb.stall_count, c0); end
        tick();
        drive(0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 5'd0, 5'd0, 2'b00, 5'd11, 1, 1, 0);
        tick();
        drive(1, 5'd0, 5'd0, 2'b00, 5'd12, 1, 1, 0);
        tick();
        drive(1, 5'd0, 5'd0, 2'b00, 5'd13, 1, 1, 0);
        tick();
        drive(1, 5'd13, 5'd11, 2'b11, 5'd0, 0, 0, 0);
        n_tests++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_stall: got %b want 1", sb.stall); end
        n_tests++; if (dut_fwd(1) !== 2'd3) begin n_fail++; $display("FAIL rmid_pre_fwd1: got %0d want 3", dut_fwd(1)); end
        rst = 1'b1;
        #1;
        n_tests++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall: got %b want 0", sb.stall); end
        n_tests++; if (dut_fwd(0) !== 2'd0) begin n_fail++; $display("FAIL rmid_fwd0: got %0d want 0", dut_fwd(0)); end
        n_tests++; if (dut_fwd(1) !== 2'd0) begin n_fail++; $display("FAIL rmid_fwd1: got %0d want 0", dut_fwd(1)); end
        n_tests++; if (sb.stall_count !== 16'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", sb.stall_count); end
        n_tests++; if (sb2.stall_count !== 2'd0) begin n_fail++; $display("FAIL rmid_count2: got %0d want 0", sb2.stall_count); end
        hist.delete();
        stalls = 0;
        drive(0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 3; r++) begin
            drive(1, 5'd0, 5'd0, 2'b00, 5'd14, 1, 1, 0);
            tick();
            drive(1, 5'd14, 5'd0, 2'b01, 5'd0, 0, 0, 0);
            tick();
            tick();
            drive(0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0);
            n_tests++; if (sb2.stall_count !== 2'(m_cnt(3))) begin n_fail++; $display("FAIL sat_count2_%0d: got %0d want %0d", r, sb2.stall_count, m_cnt(3)); end
            n_tests++; if (sb.stall_count !== 16'(m_cnt(65535))) begin n_fail++; $display("FAIL sat_count_%0d: got %0d want %0d", r, sb.stall_count, m_cnt(65535)); end
        end
        n_tests++; if (sb2.stall_count !== 2'd3) begin n_fail++; $display("FAIL sat_hold: got %0d want 3", sb2.stall_count); end
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 8,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            n_tests++; if (sb.stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, sb.stall, m_stall()); end
            n_tests++; if (sb.issue !== m_issue()) begin n_fail++; $display("FAIL rnd_issue c=%0d: got %b want %b", c, sb.issue, m_issue()); end
            n_tests++; if (sb.flush !== sb.ex_redirect) begin n_fail++; $display("FAIL rnd_flush c=%0d: got %b want %b", c, sb.flush, sb.ex_redirect); end
            n_tests++; if (dut_fwd(0) !== 2'(m_fwd(0))) begin n_fail++; $display("FAIL rnd_fwd0 c=%0d: got %0d want %0d", c, dut_fwd(0), m_fwd(0)); end
            n_tests++; if (dut_fwd(1) !== 2'(m_fwd(1))) begin n_fail++; $display("FAIL rnd_fwd1 c=%0d: got %0d want %0d", c, dut_fwd(1), m_fwd(1)); end
            n_tests++; if (sb.stall_count !== 16'(m_cnt(65535))) begin n_fail++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, sb.stall_count, m_cnt(65535)); end
            n_tests++; if (sb2.stall_count !== 2'(m_cnt(3))) begin n_fail++; $display("FAIL rnd_count2 c=%0d: got %0d want %0d", c, sb2.stall_count, m_cnt(3)); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_forward_chain();
        test_load_use();
        test_r0_unused();
        test_youngest();
        test_redirect();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
